// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Define MDU_MADD_EN to enable madd/maddu (mdOp 9/10) accumulation into {HI,LO}.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdOp,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] out
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_cnt, r_hi, r_lo, r_tmp_hi, r_tmp_lo;
    logic        r_dz;
    logic        w_is_mul, w_is_div;
    logic [63:0] w_ps, w_pu, w_tmp;
    logic [31:0] w_bd, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

`ifdef MDU_MADD_EN
    assign w_is_mul = mdOp == 4'd1 || mdOp == 4'd2 || mdOp == 4'd9 || mdOp == 4'd10;
`else
    assign w_is_mul = mdOp == 4'd1 || mdOp == 4'd2;
`endif
    assign w_is_div = mdOp == 4'd3 || mdOp == 4'd4;
    assign busy     = r_state == RUN;
    assign start    = (w_is_mul || w_is_div) && !busy && !req;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign out      = mdOp == 4'd7 ? r_hi : mdOp == 4'd8 ? r_lo : 32'd0;

    assign w_ps    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_pu    = {32'd0, A} * {32'd0, B};
    // Substitute divisor keeps the dividers defined; a zero divisor never commits.
    assign w_bd    = B == 32'd0 ? 32'd1 : B;
    assign w_quo_s = $signed(A) / $signed(w_bd);
    assign w_rem_s = $signed(A) % $signed(w_bd);
    assign w_quo_u = A / w_bd;
    assign w_rem_u = A % w_bd;

    always_comb begin
        w_tmp = 64'd0;
        w_tmp = mdOp == 4'd1 ? w_ps :
                mdOp == 4'd2 ? w_pu :
                mdOp == 4'd3 ? {w_rem_s, w_quo_s} :
                mdOp == 4'd4 ? {w_rem_u, w_quo_u} :
`ifdef MDU_MADD_EN
                mdOp == 4'd9  ? {r_hi, r_lo} + w_ps :
                mdOp == 4'd10 ? {r_hi, r_lo} + w_pu :
`endif
                64'd0;
    end

    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (start ? RUN : IDLE) : (r_cnt == 32'd1 ? IDLE : RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_tmp_hi <= 32'd0;
            r_tmp_lo <= 32'd0;
            r_dz     <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_cnt    <= w_is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                r_tmp_hi <= w_tmp[63:32];
                r_tmp_lo <= w_tmp[31:0];
                r_dz     <= w_is_div && B == 32'd0;
            end else if (!req && mdOp == 4'd5) begin
                r_hi <= A;
            end else if (!req && mdOp == 4'd6) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - 32'd1;
            if (r_cnt == 32'd1 && !r_dz) begin
                r_hi <= r_tmp_hi;
                r_lo <= r_tmp_lo;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Follows MDU_MADD_EN for the multiply-accumulate expectations.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mdOp = 4'd0;
    logic        req = 1'b0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic        start, busy;
    logic [31:0] HI, LO, out;
    int          n_cmp = 0, n_err = 0;
    logic        st;
    int          nb;

    md_unit dut (
        .clk(clk), .reset(reset), .mdOp(mdOp), .req(req), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r, output logic s);
        @(negedge clk);
        mdOp = op; A = a; B = b; req = r;
        #1 s = start;
        @(posedge clk);
        #1 mdOp = 4'd0; req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b0;

        issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, st);
        chk("mult_start", {31'd0, st}, 32'd1);
        count_busy(nb);
        chk("mult_busy", nb, 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFE);

        issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, st);
        count_busy(nb);
        chk("multu_busy", nb, 32'd5);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, st);
        count_busy(nb);
        chk("div_busy", nb, 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        issue(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0, st);
        count_busy(nb);
        chk("divu_lo", LO, 32'h7FFFFFFC);
        chk("divu_hi", HI, 32'h00000001);

        issue(4'd5, 32'h1234, 32'd0, 1'b0, st);
        chk("mthi", HI, 32'h1234);
        issue(4'd6, 32'h5678, 32'd0, 1'b0, st);
        chk("mtlo", LO, 32'h5678);
        issue(4'd3, 32'd77, 32'd0, 1'b0, st);
        count_busy(nb);
        chk("dz_busy", nb, 32'd10);
        chk("dz_hi", HI, 32'h1234);
        chk("dz_lo", LO, 32'h5678);
        @(negedge clk);
        mdOp = 4'd7; #1 chk("mfhi", out, 32'h1234);
        mdOp = 4'd8; #1 chk("mflo", out, 32'h5678);
        mdOp = 4'd0; #1 chk("out_none", out, 32'd0);

        issue(4'd1, 32'd3, 32'd3, 1'b1, st);
        chk("flush_start", {31'd0, st}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", HI, 32'h1234);
        issue(4'd6, 32'hAAAA, 32'd0, 1'b1, st);
        chk("flush_mtlo", LO, 32'h5678);
        issue(4'd11, 32'd3, 32'd3, 1'b0, st);
        chk("unk_start", {31'd0, st}, 32'd0);

        issue(4'd3, 32'd100, 32'd7, 1'b0, st);
        issue(4'd5, 32'hDEAD, 32'd0, 1'b0, st);
        issue(4'd1, 32'd9, 32'd9, 1'b0, st);
        chk("busy_start", {31'd0, st}, 32'd0);
        issue(4'd6, 32'hBEEF, 32'd0, 1'b0, st);
        count_busy(nb);
        chk("busy_rest", nb, 32'd7);
        chk("busy_hi", HI, 32'd2);
        chk("busy_lo", LO, 32'd14);

        issue(4'd3, 32'd50, 32'd3, 1'b0, st);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_nocommit_hi", HI, 32'd0);
        chk("abort_nocommit_lo", LO, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, st);
        issue(4'd10, 32'd1, 32'd1, 1'b0, st);
        count_busy(nb);
`ifdef MDU_MADD_EN
        chk("maddu_start", {31'd0, st}, 32'd1);
        chk("maddu_busy", nb, 32'd5);
        chk("maddu_hi", HI, 32'd1);
        chk("maddu_lo", LO, 32'd0);
`else
        chk("maddu_start", {31'd0, st}, 32'd0);
        chk("maddu_busy", nb, 32'd0);
        chk("maddu_hi", HI, 32'd0);
        chk("maddu_lo", LO, 32'hFFFFFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
